// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits with timeout,
// branch flushes, load-use bubbles and a halt/drain/resume sequence.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT  = 64,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_write_reg,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_flush,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {
      S_RUN      = 3'd0,
      S_MEM_WAIT = 3'd1,
      S_DRAIN    = 3'd2,
      S_HALTED   = 3'd3,
      S_ERROR    = 3'd4
   } state_t;

   state_t               state, state_next;
   logic [WAIT_W-1:0]    wait_cnt, wait_cnt_next;
   logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_next;
   logic                 stall_inc, flush_inc;
   logic                 load_use, wait_now, wait_hit, drain_last;

   assign load_use = ex_MemRead && (ex_write_reg != 5'd0) &&
                     ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));

   // MEM_WAIT keeps freezing on mem_ready alone; the access is already in flight.
   assign wait_now = ((state == S_RUN || state == S_DRAIN) && mem_req && !mem_ready) ||
                     ((state == S_MEM_WAIT) && !mem_ready);
   assign wait_hit   = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
   assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_CYCLES));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         wait_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_next;
         wait_cnt  <= wait_cnt_next;
         drain_cnt <= drain_cnt_next;
      end
   end

   always_comb begin
      state_next     = state;
      wait_cnt_next  = '0;
      drain_cnt_next = drain_cnt;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
      case (state)
         S_RUN, S_MEM_WAIT: begin
            if (wait_now) begin
               stall_inc     = 1'b1;
               wait_cnt_next = wait_hit ? '0 : wait_cnt + WAIT_W'(1);
               state_next    = wait_hit ? S_ERROR : S_MEM_WAIT;
            end else if (ex_branch_taken) begin
               flush_inc  = 1'b1;
               state_next = S_RUN;
            end else if (load_use) begin
               stall_inc  = 1'b1;
               state_next = S_RUN;
            end else if (halt_req) begin
               drain_cnt_next = DRAIN_W'(1);
               state_next     = S_DRAIN;
            end else begin
               state_next = S_RUN;
            end
         end
         S_DRAIN: begin
            if (wait_now) begin
               stall_inc     = 1'b1;
               wait_cnt_next = wait_hit ? '0 : wait_cnt + WAIT_W'(1);
               if (wait_hit) state_next = S_ERROR;
            end else begin
               flush_inc = ex_branch_taken;
               if (drain_last) begin
                  drain_cnt_next = '0;
                  state_next     = S_HALTED;
               end else begin
                  drain_cnt_next = drain_cnt + DRAIN_W'(1);
               end
            end
         end
         S_HALTED: begin
            if (!halt_req) begin
               drain_cnt_next = '0;
               state_next     = S_RUN;
            end
         end
         default: state_next = S_ERROR;
      endcase
   end

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      if (rst || state == S_HALTED || state == S_ERROR) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (wait_now) begin
         // Freeze: hold the front, let WB retire into a bubble.
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
      end else if (state == S_DRAIN) begin
         pc_en      = ex_branch_taken;
         ifid_flush = 1'b1;
         idex_flush = ex_branch_taken;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (halt_req) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   assign halted = !rst && (state == S_HALTED);
   assign err    = !rst && (state == S_ERROR);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_inc && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_inc && (flush_count != {CNT_W{1'b1}}))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// each cycle's outputs predicted by a behavioural model and checked by a monitor.
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT  = 4;
   localparam int DRAIN_CYCLES = 3;
   localparam int CNT_W        = 4;
   localparam int OUT_W        = 10 + 2 * CNT_W;
   localparam int CMAX         = (1 << CNT_W) - 1;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [4:0]       id_rs, id_rt, ex_write_reg;
   logic             id_uses_rt, ex_MemRead, ex_branch_taken;
   logic             mem_req, mem_ready, halt_req;
   logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic             ifid_flush, idex_flush, memwb_flush, halted, err;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_MemRead(ex_MemRead), .ex_write_reg(ex_write_reg),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .halt_req(halt_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .memwb_flush(memwb_flush), .halted(halted), .err(err),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   // scoreboard
   logic [OUT_W-1:0] exp_q[$];
   int               cyc_q[$];
   int               checks = 0;
   int               passes = 0;
   int               pushed = 0;
   int               cycle_no = 0;

   // behavioural model of the pipeline control
   bit m_err, m_halted, m_draining, m_waiting;
   int m_drains_left, m_wait_run, m_stall, m_flush;

   task automatic model_eval(output logic [OUT_W-1:0] e);
      bit en_pc, en_ifid, en_idex, en_exmem, en_memwb, f_ifid, f_idex, f_memwb;
      bit lu, mem_block;
      logic [CNT_W-1:0] s_now, f_now;
      s_now = CNT_W'(m_stall);
      f_now = CNT_W'(m_flush);
      {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
      {f_ifid, f_idex, f_memwb} = 3'b000;
      lu = ex_MemRead && ex_write_reg != 0 &&
           (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt));
      if (rst) begin
         {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
         e = {5'b00000, 3'b000, 1'b0, 1'b0, s_now, f_now};
         m_err = 0; m_halted = 0; m_draining = 0; m_waiting = 0;
         m_drains_left = 0; m_wait_run = 0; m_stall = 0; m_flush = 0;
         return;
      end
      if (m_err) begin
         e = {5'b00000, 3'b000, 1'b0, 1'b1, s_now, f_now};
         return;
      end
      if (m_halted) begin
         e = {5'b00000, 3'b000, 1'b1, 1'b0, s_now, f_now};
         if (!halt_req) m_halted = 0;
         return;
      end
      mem_block = m_waiting ? !mem_ready : (mem_req && !mem_ready);
      if (mem_block) begin
         {en_pc, en_ifid, en_idex, en_exmem} = 4'b0000;
         f_memwb = 1;
         m_stall = (m_stall < CMAX) ? m_stall + 1 : m_stall;
         m_wait_run++;
         if (m_wait_run == MEM_TIMEOUT) begin
            m_err = 1; m_waiting = 0; m_draining = 0;
         end else if (!m_draining) begin
            m_waiting = 1;
         end
      end else begin
         m_wait_run = 0;
         m_waiting = 0;
         if (m_draining) begin
            en_pc = ex_branch_taken;
            f_ifid = 1;
            f_idex = ex_branch_taken;
            if (ex_branch_taken) m_flush = (m_flush < CMAX) ? m_flush + 1 : m_flush;
            m_drains_left--;
            if (m_drains_left == 0) begin
               m_draining = 0; m_halted = 1;
            end
         end else if (ex_branch_taken) begin
            f_ifid = 1; f_idex = 1;
            m_flush = (m_flush < CMAX) ? m_flush + 1 : m_flush;
         end else if (lu) begin
            en_pc = 0; en_ifid = 0; f_idex = 1;
            m_stall = (m_stall < CMAX) ? m_stall + 1 : m_stall;
         end else if (halt_req) begin
            en_pc = 0; f_ifid = 1;
            m_draining = 1; m_drains_left = DRAIN_CYCLES;
         end
      end
      e = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, f_ifid, f_idex, f_memwb,
           1'b0, 1'b0, s_now, f_now};
   endtask

   // driver tasks
   task automatic tick();
      logic [OUT_W-1:0] e;
      model_eval(e);
      exp_q.push_back(e);
      cyc_q.push_back(cycle_no);
      pushed++;
      cycle_no++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rst = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_MemRead = 0;
      ex_write_reg = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0; halt_req = 0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic set_load_use(input logic [4:0] r);
      ex_MemRead = 1; ex_write_reg = r; id_rs = r;
   endtask

   // monitor
   always @(negedge clk) begin
      logic [OUT_W-1:0] e, a;
      int c;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         c = cyc_q.pop_front();
         a = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
              memwb_flush, halted, err, stall_cycles, flush_count};
         checks++;
         if (a === e) passes++;
         else $display("FAIL cycle %0d outputs {en5,flush3,halted,err,stall,flush}: got %h expected %h",
                       c, a, e);
      end
   end

   initial begin
      set_idle();
      rst = 1;
      @(posedge clk);
      #1;
      do_reset();
      do_reset();

      // load-use via rs, then ex_write_reg=0, then via rt
      set_load_use(5'd5); tick();
      set_idle(); tick();
      ex_MemRead = 1; ex_write_reg = 0; id_rs = 0; tick();
      set_idle(); ex_MemRead = 1; ex_write_reg = 7; id_rt = 7; id_uses_rt = 1; tick();
      id_uses_rt = 0; tick();

      // branch beats load-use
      set_idle(); set_load_use(5'd3); ex_branch_taken = 1; tick();
      set_idle(); tick();

      // three-cycle memory wait
      do_reset();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++) tick();
      mem_ready = 1; tick();
      set_idle(); tick();

      // timeout, then recovery through reset
      do_reset();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 7; i++) tick();
      do_reset();
      tick();

      // halt, drain, resume
      do_reset();
      halt_req = 1;
      for (int i = 0; i < 6; i++) tick();
      halt_req = 0; tick(); tick();

      // memory wait inside drain
      do_reset();
      halt_req = 1; tick();
      mem_req = 1; mem_ready = 0; tick(); tick();
      mem_req = 0; halt_req = 0;
      for (int i = 0; i < 5; i++) tick();

      // branch coincident with halt, then branch during drain
      do_reset();
      halt_req = 1; ex_branch_taken = 1; tick();
      ex_branch_taken = 0; tick();
      ex_branch_taken = 1; tick();
      ex_branch_taken = 0;
      for (int i = 0; i < 4; i++) tick();
      halt_req = 0; tick();

      // counter saturation
      do_reset();
      set_load_use(5'd9);
      for (int i = 0; i < 20; i++) tick();
      set_idle(); ex_branch_taken = 1;
      for (int i = 0; i < 18; i++) tick();

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst             = ($urandom_range(0, 99) == 0);
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_MemRead      = 1'($urandom_range(0, 1));
         ex_write_reg    = 5'($urandom_range(0, 3));
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         mem_req         = ($urandom_range(0, 3) == 0);
         mem_ready       = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
         tick();
      end

      set_idle();
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0 && checks == pushed + 1) passes++;
      else $display("FAIL scoreboard drain: got %0d left/%0d checked, expected 0 left/%0d checked",
                    exp_q.size(), checks - 1, pushed);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
